// File: rtl/axis_usb_cmd_decoder_if.sv
// AXI4-Stream link between the USB FIFO bridge and the command decoder.
// Ports: tdata/tvalid driven by master, tready driven by slave.
interface axis_usb_cmd_decoder_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tready;

  modport master (
    output tdata,
    output tvalid,
    input  tready
  );

  modport slave (
    input  tdata,
    input  tvalid,
    output tready
  );
endinterface

// File: rtl/axis_usb_cmd_decoder.sv
// Host command decoder: turns USB host words into register-bus bursts.
// Ports: aclk/aresetn, s_axis (host words in), m_axis (replies out),
//        bus_* register bus, busy, cmd_cntr (completed commands).
module axis_usb_cmd_decoder #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  axis_usb_cmd_decoder_if.slave  s_axis,
  axis_usb_cmd_decoder_if.master m_axis,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [31:0]           bus_wdata,
  output logic                  bus_wren,
  output logic                  bus_rden,
  input  logic [31:0]           bus_rdata,
  output logic                  busy,
  output logic [31:0]           cmd_cntr
);

  localparam int AW = ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR,
    S_WDATA,
    S_ACK,
    S_ERR,
    S_RHDR,
    S_RISSUE,
    S_RCAP,
    S_RSEND
  } state_t;

  state_t        state;
  logic          s_rdy;
  logic [31:0]   m_data;
  logic          m_vld;
  logic [11:0]   hdr_n;
  logic [15:0]   hdr_a;
  logic [11:0]   rem;
  logic [AW-1:0] addr;

  logic          s_hs;
  logic          m_hs;
  logic [3:0]    h_op;
  logic [11:0]   h_n;
  logic [15:0]   h_a;
  logic          is_nop;
  logic          is_wr;
  logic          is_rd;
  logic          is_bad;

  assign s_axis.tready = s_rdy;
  assign m_axis.tdata  = m_data;
  assign m_axis.tvalid = m_vld;

  assign s_hs = s_axis.tvalid & s_rdy;
  assign m_hs = m_vld & m_axis.tready;

  assign h_op = s_axis.tdata[31:28];
  assign h_n  = s_axis.tdata[27:16];
  assign h_a  = s_axis.tdata[15:0];

  assign is_nop = (h_op == 4'h0);
  assign is_wr  = (h_op == 4'h1);
  assign is_rd  = (h_op == 4'h2);
  assign is_bad = (h_op > 4'h2);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= S_HDR;
      s_rdy     <= 1'b0;
      m_data    <= '0;
      m_vld     <= 1'b0;
      hdr_n     <= '0;
      hdr_a     <= '0;
      rem       <= '0;
      addr      <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wren  <= 1'b0;
      bus_rden  <= 1'b0;
      busy      <= 1'b0;
      cmd_cntr  <= '0;
    end else begin
      bus_wren <= 1'b0;
      bus_rden <= 1'b0;
      unique case (state)
        S_HDR: begin
          s_rdy <= 1'b1;
          busy  <= 1'b0;
          if (s_hs) begin
            hdr_n <= h_n;
            hdr_a <= h_a;
            rem   <= h_n;
            addr  <= h_a[AW-1:0];
            unique case (1'b1)
              is_nop: begin
                cmd_cntr <= cmd_cntr + 32'd1;
              end
              is_wr: begin
                busy <= 1'b1;
                if (h_n != 12'd0) begin
                  state <= S_WDATA;
                end else begin
                  state  <= S_ACK;
                  s_rdy  <= 1'b0;
                  m_data <= {4'h1, h_n, h_a};
                  m_vld  <= 1'b1;
                end
              end
              is_rd: begin
                state  <= S_RHDR;
                busy   <= 1'b1;
                s_rdy  <= 1'b0;
                m_data <= {4'h2, h_n, h_a};
                m_vld  <= 1'b1;
              end
              is_bad: begin
                // Unknown opcode: no data words follow, next word is a header.
                state  <= S_ERR;
                busy   <= 1'b1;
                s_rdy  <= 1'b0;
                m_data <= {4'hF, h_n, h_a};
                m_vld  <= 1'b1;
              end
            endcase
          end
        end

        S_WDATA: begin
          if (s_hs) begin
            bus_addr  <= addr;
            bus_wdata <= s_axis.tdata;
            bus_wren  <= 1'b1;
            addr      <= addr + AW'(1);
            rem       <= rem - 12'd1;
            if (rem == 12'd1) begin
              state  <= S_ACK;
              s_rdy  <= 1'b0;
              m_data <= {4'h1, hdr_n, hdr_a};
              m_vld  <= 1'b1;
            end
          end
        end

        S_ACK: begin
          if (m_hs) begin
            m_vld    <= 1'b0;
            cmd_cntr <= cmd_cntr + 32'd1;
            state    <= S_HDR;
            s_rdy    <= 1'b1;
            busy     <= 1'b0;
          end
        end

        S_ERR: begin
          if (m_hs) begin
            m_vld <= 1'b0;
            state <= S_HDR;
            s_rdy <= 1'b1;
            busy  <= 1'b0;
          end
        end

        S_RHDR: begin
          if (m_hs) begin
            m_vld <= 1'b0;
            if (rem != 12'd0) begin
              state    <= S_RISSUE;
              bus_rden <= 1'b1;
              bus_addr <= addr;
            end else begin
              state    <= S_HDR;
              cmd_cntr <= cmd_cntr + 32'd1;
              s_rdy    <= 1'b1;
              busy     <= 1'b0;
            end
          end
        end

        // bus_rden is high during this state; data arrives next cycle.
        S_RISSUE: begin
          state <= S_RCAP;
        end

        S_RCAP: begin
          m_data <= bus_rdata;
          m_vld  <= 1'b1;
          state  <= S_RSEND;
        end

        // Next read is issued only after the held word is taken.
        S_RSEND: begin
          if (m_hs) begin
            m_vld <= 1'b0;
            addr  <= addr + AW'(1);
            rem   <= rem - 12'd1;
            if (rem == 12'd1) begin
              state    <= S_HDR;
              cmd_cntr <= cmd_cntr + 32'd1;
              s_rdy    <= 1'b1;
              busy     <= 1'b0;
            end else begin
              state    <= S_RISSUE;
              bus_rden <= 1'b1;
              bus_addr <= addr + AW'(1);
            end
          end
        end

        default: begin
          state <= S_HDR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axis_usb_cmd_decoder.sv
// Scoreboard bench for axis_usb_cmd_decoder.
// Drives host words, models the register bus, checks replies and writes.
module tb_axis_usb_cmd_decoder;

  logic        usb_clk;
  logic        rst_n;
  logic [15:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_wren;
  logic        bus_rden;
  logic [31:0] bus_rdata;
  logic        busy;
  logic [31:0] cmd_cntr;

  axis_usb_cmd_decoder_if s_if ();
  axis_usb_cmd_decoder_if m_if ();

  axis_usb_cmd_decoder #(
    .ADDR_WIDTH(16)
  ) dut (
    .aclk      (usb_clk),
    .aresetn   (rst_n),
    .s_axis    (s_if),
    .m_axis    (m_if),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_wren  (bus_wren),
    .bus_rden  (bus_rden),
    .bus_rdata (bus_rdata),
    .busy      (busy),
    .cmd_cntr  (cmd_cntr)
  );

  int          checks = 0;
  int          errors = 0;
  int          rden_cnt = 0;
  bit          toggle_rdy = 0;
  logic [31:0] exp_reply[$];
  logic [47:0] exp_wr[$];
  logic        prev_v = 0;
  logic        prev_r = 0;
  logic [31:0] prev_d = 0;

  initial usb_clk = 0;
  always #5 usb_clk = ~usb_clk;

  // Register bus: read data valid the cycle after bus_rden.
  always @(posedge usb_clk) begin
    if (bus_rden) bus_rdata <= 32'h100 + {16'h0, bus_addr};
  end

  always @(posedge usb_clk) begin
    #1;
    m_if.tready = toggle_rdy ? ~m_if.tready : 1'b1;
  end

  always @(negedge usb_clk) begin
    if (rst_n) begin
      if (bus_wren && bus_rden) begin
        checks++; errors++;
        $display("FAIL wren_rden both high");
      end
      if (bus_rden) rden_cnt++;
      if (bus_wren) begin
        checks++;
        if (exp_wr.size() == 0) begin
          errors++;
          $display("FAIL bus_write unexpected got %h/%h", bus_addr, bus_wdata);
        end else begin
          logic [47:0] w;
          w = exp_wr.pop_front();
          if ({bus_addr, bus_wdata} !== w) begin
            errors++;
            $display("FAIL bus_write got %h/%h want %h/%h",
                     bus_addr, bus_wdata, w[47:32], w[31:0]);
          end
        end
      end
      if (prev_v && !prev_r) begin
        checks++;
        if (!m_if.tvalid || m_if.tdata !== prev_d) begin
          errors++;
          $display("FAIL m_hold got v=%b %h want v=1 %h",
                   m_if.tvalid, m_if.tdata, prev_d);
        end
      end
      if (m_if.tvalid && m_if.tready) begin
        checks++;
        if (exp_reply.size() == 0) begin
          errors++;
          $display("FAIL reply unexpected got %h", m_if.tdata);
        end else begin
          logic [31:0] r;
          r = exp_reply.pop_front();
          if (m_if.tdata !== r) begin
            errors++;
            $display("FAIL reply got %h want %h", m_if.tdata, r);
          end
        end
      end
      prev_v = m_if.tvalid;
      prev_r = m_if.tready;
      prev_d = m_if.tdata;
    end else begin
      prev_v = 0;
    end
  end

  task automatic send_word(input logic [31:0] w);
    int n;
    n = 0;
    s_if.tdata  = w;
    s_if.tvalid = 1'b1;
    while (1) begin
      @(negedge usb_clk);
      if (s_if.tready) break;
      n++;
      if (n > 300) begin
        checks++; errors++;
        $display("FAIL s_accept timeout word %h", w);
        break;
      end
    end
    @(posedge usb_clk);
    #1;
    s_if.tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (1) begin
      @(negedge usb_clk);
      if (!busy && !m_if.tvalid && exp_reply.size() == 0 &&
          exp_wr.size() == 0) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL %s idle timeout left r=%0d w=%0d",
                 tag, exp_reply.size(), exp_wr.size());
        exp_reply.delete();
        exp_wr.delete();
        break;
      end
    end
    @(posedge usb_clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 0;
    s_if.tvalid = 0;
    s_if.tdata = '0;
    repeat (3) @(posedge usb_clk);
    @(negedge usb_clk);
    checks++;
    if ({s_if.tready, m_if.tvalid, m_if.tdata, bus_addr, bus_wdata,
         bus_wren, bus_rden, busy, cmd_cntr} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h a=%h w=%h",
               s_if.tready, m_if.tvalid, m_if.tdata, bus_addr, bus_wdata);
    end
    rst_n = 1;
    @(negedge usb_clk);
    checks++;
    if (s_if.tready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b busy=%b want 1/0",
               s_if.tready, busy);
    end
    @(posedge usb_clk);
    #1;
  endtask

  task automatic test_write;
    exp_wr.push_back({16'h0010, 32'hA});
    exp_wr.push_back({16'h0011, 32'hB});
    exp_wr.push_back({16'h0012, 32'hC});
    exp_reply.push_back(32'h1003_0010);
    send_word(32'h1003_0010);
    send_word(32'hA);
    send_word(32'hB);
    send_word(32'hC);
    wait_idle("write");
    checks++;
    if (cmd_cntr !== 32'd1) begin
      errors++;
      $display("FAIL write_cntr got %0d want 1", cmd_cntr);
    end
  endtask

  task automatic test_read_backpressure;
    int r0;
    r0 = rden_cnt;
    toggle_rdy = 1;
    exp_reply.push_back(32'h2002_00FE);
    exp_reply.push_back(32'h0000_01FE);
    exp_reply.push_back(32'h0000_01FF);
    send_word(32'h2002_00FE);
    wait_idle("read");
    toggle_rdy = 0;
    checks++;
    if (rden_cnt - r0 !== 2) begin
      errors++;
      $display("FAIL read_rden got %0d want 2", rden_cnt - r0);
    end
    checks++;
    if (cmd_cntr !== 32'd2) begin
      errors++;
      $display("FAIL read_cntr got %0d want 2", cmd_cntr);
    end
  endtask

  task automatic test_addr_wrap;
    exp_wr.push_back({16'hFFFF, 32'h1});
    exp_wr.push_back({16'h0000, 32'h2});
    exp_reply.push_back(32'h1002_FFFF);
    send_word(32'h1002_FFFF);
    send_word(32'h1);
    send_word(32'h2);
    wait_idle("wrap");
    checks++;
    if (cmd_cntr !== 32'd3) begin
      errors++;
      $display("FAIL wrap_cntr got %0d want 3", cmd_cntr);
    end
  endtask

  task automatic test_nop_err;
    logic [31:0] c0;
    c0 = cmd_cntr;
    exp_reply.push_back(32'hF001_1234);
    exp_reply.push_back(32'h1000_0005);
    send_word(32'h0000_0000);
    send_word(32'h7001_1234);
    send_word(32'h1000_0005);
    wait_idle("nop_err");
    checks++;
    if (cmd_cntr - c0 !== 32'd2) begin
      errors++;
      $display("FAIL nop_err_cntr got +%0d want +2", cmd_cntr - c0);
    end
  endtask

  task automatic test_read_zero;
    int r0;
    int n;
    logic [31:0] c0;
    r0 = rden_cnt;
    c0 = cmd_cntr;
    n = 0;
    exp_reply.push_back(32'h2000_0040);
    send_word(32'h2000_0040);
    while (1) begin
      @(negedge usb_clk);
      if (m_if.tvalid && m_if.tready) break;
      n++;
      if (n > 50) begin
        checks++; errors++;
        $display("FAIL read0_echo timeout");
        break;
      end
    end
    @(negedge usb_clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL read0_busy got %b want 0", busy);
    end
    wait_idle("read0");
    checks++;
    if (rden_cnt != r0 || cmd_cntr - c0 !== 32'd1) begin
      errors++;
      $display("FAIL read0_side got rden+%0d cntr+%0d want 0/1",
               rden_cnt - r0, cmd_cntr - c0);
    end
  endtask

  task automatic test_reset_mid_burst;
    exp_wr.push_back({16'h0030, 32'h11});
    exp_wr.push_back({16'h0031, 32'h22});
    send_word(32'h1004_0030);
    send_word(32'h11);
    send_word(32'h22);
    @(negedge usb_clk);
    #1;
    rst_n = 0;
    #1;
    checks++;
    if ({s_if.tready, m_if.tvalid, m_if.tdata, bus_addr, bus_wdata,
         bus_wren, bus_rden, busy, cmd_cntr} !== '0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b busy=%b a=%h w=%h cntr=%0d",
               s_if.tready, busy, bus_addr, bus_wdata, cmd_cntr);
    end
    checks++;
    if (exp_wr.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_writes got %0d pending want 0", exp_wr.size());
      exp_wr.delete();
    end
    repeat (2) @(posedge usb_clk);
    #2;
    rst_n = 1;
    @(posedge usb_clk);
    #1;
    exp_wr.push_back({16'h0020, 32'h55});
    exp_reply.push_back(32'h1001_0020);
    send_word(32'h1001_0020);
    send_word(32'h55);
    wait_idle("mid_reset");
    checks++;
    if (cmd_cntr !== 32'd1) begin
      errors++;
      $display("FAIL mid_reset_cntr got %0d want 1", cmd_cntr);
    end
  endtask

  initial begin
    m_if.tready = 1'b1;
    bus_rdata = '0;
    test_reset();
    test_write();
    test_read_backpressure();
    test_addr_wrap();
    test_nop_err();
    test_read_zero();
    test_reset_mid_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
